// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE -> EXEC -> RESP handshake.
// Define ALU_ARB_RR_EN for round-robin arbitration; default build uses fixed priority (req0).
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [1:0]  op0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        req1,
    input  logic [1:0]  op1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready
);
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OP1 = 2'd2;
    localparam logic [1:0] ALU_OP2 = 2'd3;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        id_q, id_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        grant;
    logic        win_id;
    logic [31:0] alu_res;

    assign grant = (state_q == StIdle) & ~rst & (req0 | req1);

`ifdef ALU_ARB_RR_EN
    // ptr_q holds the last granted id; on contention the other requester wins.
    logic ptr_q, ptr_d;

    always_comb begin
        win_id = req1 & (~req0 | ~ptr_q);
        ptr_d  = ptr_q;
        if (grant) begin
            ptr_d = win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win_id = ~req0;
    end
`endif

    assign gnt0      = grant & ~win_id;
    assign gnt1      = grant & win_id;
    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        unique case (op_q)
            ALU_ADD: alu_res = a_q + b_q;
            ALU_SUB: alu_res = a_q - b_q;
            ALU_OP1: alu_res = a_q;
            ALU_OP2: alu_res = b_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    op_d    = win_id ? op1 : op0;
                    a_d     = win_id ? a1 : a0;
                    b_d     = win_id ? b1 : b0;
                    id_d    = win_id;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_data_d = alu_res;
                rsp_id_d   = id_q;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= 2'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, hand sequences and randomized transactions.
// Honours ALU_ARB_RR_EN the same way as the design.
module tb_alu_arbiter;
    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] OP1 = 2'd2;
    localparam logic [1:0] OP2 = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .op0       (op0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .op1       (op1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    typedef struct {
        logic        r0;
        logic [1:0]  o0;
        logic [31:0] va0;
        logic [31:0] vb0;
        logic        r1;
        logic [1:0]  o1;
        logic [31:0] va1;
        logic [31:0] vb1;
        logic        eid;
        logic [31:0] edata;
        int          stall;
    } vec_t;

    vec_t vecs [6];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic last_id;   // model of last granted requester

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            OP1:     return a;
            default: return b;
        endcase
    endfunction

    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef ALU_ARB_RR_EN
            return ~last_id;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Inputs must already be applied in an IDLE cycle; checks grant, latency, hold and release.
    task automatic txn(input logic eid, input logic [31:0] edata, input int stall);
        settle;
        check("gnt0_grant", gnt0, !eid);
        check("gnt1_grant", gnt1, eid);
        last_id = eid;
        step;
        // Winner drops its request and scribbles its operands; the result must not change.
        if (eid) begin
            req1 = 1'b0; a1 = 32'd100; b1 = ~b1; op1 = ~op1;
        end else begin
            req0 = 1'b0; a0 = 32'd100; b0 = ~b0; op0 = ~op0;
        end
        settle;
        check("exec_valid", rsp_valid, 0);
        check("exec_gnt", {gnt1, gnt0}, 0);
        step;
        for (int s = 0; s <= stall; s++) begin
            rsp_ready = (s == stall);
            settle;
            check("resp_valid", rsp_valid, 1);
            check("resp_id", rsp_id, eid);
            check("resp_data", rsp_data, edata);
            check("resp_gnt", {gnt1, gnt0}, 0);
            step;
        end
        rsp_ready = 1'b0;
        settle;
        check("idle_valid", rsp_valid, 0);
    endtask

    initial begin
        logic exp_seq [4];
        logic r0, r1, w;
        logic [31:0] edata;

        vecs[0] = '{1, ADD, 32'd5, 32'd7, 0, ADD, 0, 0, 0, 32'd12, 0};
        vecs[1] = '{0, ADD, 0, 0, 1, SUB, 32'd0, 32'd1, 1, 32'hFFFF_FFFF, 0};
        vecs[2] = '{0, ADD, 0, 0, 1, OP2, 32'd1234, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0};
        vecs[3] = '{1, OP1, 32'd3, 32'd9, 0, ADD, 0, 0, 0, 32'd3, 0};
        vecs[4] = '{1, ADD, 32'hFFFF_FFFF, 32'd2, 0, ADD, 0, 0, 0, 32'd1, 5};
        vecs[5] = '{0, ADD, 0, 0, 1, SUB, 32'd10, 32'd3, 1, 32'd7, 2};
`ifdef ALU_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = ADD; op1 = ADD;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_ready = 1'b0;
        step;
        step;
        req0 = 1'b1;
        settle;
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_data", rsp_data, 0);
        req0 = 1'b0;
        step;
        rst = 1'b0;
        last_id = 1'b1;

        foreach (vecs[i]) begin
            req0 = vecs[i].r0; op0 = vecs[i].o0; a0 = vecs[i].va0; b0 = vecs[i].vb0;
            req1 = vecs[i].r1; op1 = vecs[i].o1; a1 = vecs[i].va1; b1 = vecs[i].vb1;
            txn(vecs[i].eid, vecs[i].edata, vecs[i].stall);
        end

        // Reset during EXEC aborts the ADD 1+1 and restores requester-0 preference.
        req0 = 1'b1; op0 = ADD; a0 = 32'd1; b0 = 32'd1;
        settle;
        check("abort_gnt0", gnt0, 1);
        step;
        req0 = 1'b0; req1 = 1'b1; rst = 1'b1; rsp_ready = 1'b1;
        settle;
        check("abort_rst_gnt", {gnt1, gnt0}, 0);
        step;
        rst = 1'b0; req1 = 1'b0; last_id = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle;
            check("abort_no_valid", rsp_valid, 0);
            step;
        end
        rsp_ready = 1'b0;

        for (int t = 0; t < 4; t++) begin
            req0 = 1'b1; op0 = SUB; a0 = 32'd50 + t; b0 = 32'd8;
            req1 = 1'b1; op1 = ADD; a1 = 32'd1000; b1 = t;
            edata = exp_seq[t] ? (32'd1000 + t) : (32'd42 + t);
            txn(exp_seq[t], edata, t % 2);
        end
        req0 = 1'b0; req1 = 1'b0;

        for (int it = 0; it < 60; it++) begin
            r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
            op0 = 2'($urandom_range(0, 3)); op1 = 2'($urandom_range(0, 3));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            req0 = r0; req1 = r1;
            if (!r0 && !r1) begin
                settle;
                check("rand_idle_gnt", {gnt1, gnt0}, 0);
                step;
            end else begin
                w = pick(r0, r1);
                edata = w ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
                txn(w, edata, $urandom_range(0, 2));
            end
            req0 = 1'b0; req1 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 req0  input  1  requester 0 wants an operation; op0/a0/b0 held stable until gnt0.
REQ-004 op0  input  2  requester 0 ALU op; encodings ALU_ADD/ALU_SUB/ALU_OP1/ALU_OP2 from the shared parameter header.
REQ-005 a0, b0  input  32 each  requester 0 operands (src1, src2).
REQ-006 req1, op1, a1, b1  input  1/2/32/32  requester 1, same semantics as requester 0.
REQ-007 gnt0, gnt1  output  1 each  one-cycle accept pulse; at most one high per cycle.
REQ-008 rsp_valid  output  1  rsp_id/rsp_data valid.
REQ-009 rsp_id  output  1  index of requester owning the response.
REQ-010 rsp_data  output  32  ALU result.
REQ-011 rsp_ready  input  1  consumer accepts response when high together with rsp_valid.

Function
REQ-012 Block SHALL contain one shared ALU: ADD = a+b, SUB = a-b (mod 2^32, no carry/overflow flag), OP1 = a, OP2 = b.
REQ-013 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-014 IDLE: if any req high, SHALL assert gnt of the winner combinationally in the same cycle, latch winner's op/a/b/id at the edge, go to EXEC; else stay IDLE.
REQ-015 EXEC: SHALL compute ALU result from latched operands and register it into rsp_data at the edge; go to RESP.
REQ-016 RESP: rsp_valid SHALL be 1; rsp_id/rsp_data SHALL stay stable until handshake; on rsp_ready=1 go to IDLE, else stay in RESP.
REQ-017 Latency: request granted in cycle N SHALL give rsp_valid in cycle N+2; next grant no earlier than N+3.
REQ-018 gnt0/gnt1 SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait (no loss, no queuing beyond the held req).
REQ-019 Arbitration with both req high SHALL follow REQ-026/REQ-027; single requester always wins.
REQ-020 rsp_valid SHALL be 0 in IDLE and EXEC; rsp_data/rsp_id are don't-care when rsp_valid=0 but SHALL hold last value.
REQ-021 Latched op/operands SHALL be immune to input changes after the grant edge.

Reset
REQ-022 rst=1 SHALL force state IDLE, gnt0=gnt1=0, rsp_valid=0, rsp_id=0, rsp_data=0, priority pointer=1 (requester 0 preferred next), on the next rising edge.
REQ-023 rst asserted in EXEC or RESP SHALL abort the transaction; no response for it is ever produced.
REQ-024 gnt0/gnt1 SHALL be 0 during any cycle with rst=1.

Configuration
REQ-025 Macro ALU_ARB_RR_EN selects the arbitration policy.
REQ-026 With ALU_ARB_RR_EN defined: round-robin; 1-bit pointer holds last granted id; on contention the other requester wins; pointer updates only on a grant.
REQ-027 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins on contention; pointer logic absent.

Verification
REQ-028 Single: req0, op=ADD, a0=5, b0=7 -> gnt0 in cycle N, rsp_valid cycle N+2, rsp_id=0, rsp_data=12.
REQ-029 Wrap/SUB: req1, op=SUB, a1=0, b1=1 -> rsp_id=1, rsp_data=0xFFFFFFFF; op=OP2, b1=0xDEADBEEF -> rsp_data=0xDEADBEEF.
REQ-030 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable all 5 cycles, no gnt; rsp_ready=1 -> IDLE next cycle.
REQ-031 Contention: req0 and req1 held high for 4 transactions -> RR build: grants 0,1,0,1; fixed build: 0,0,0,0 with req1 starved.
REQ-032 Reset mid-op: rst in EXEC after grant of ADD 1+1 -> rsp_valid never rises for it; first post-reset contention grants requester 0.
REQ-033 Operand change: alter a0 to 100 the cycle after gnt0 of OP1 a0=3 -> rsp_data=3.
